// File: rtl/cmp_search.sv
// -----------------------------------------------------------------------------
// cmp_search
// Hash-table lookup engine. Drains configuration rows {end, valid, hash, addr}
// into a private sorted table RAM, latches the binary-search start point and
// step, acknowledges each configuration, then answers one lookup at a time
// with a hit/miss flag and the row index where the search ended.
//
// Ports
//   clk, rst            : core clock, asynchronous active-high reset
//   hash_in/hash_addr_in/hash_valid_in/hash_end_in : config row being offered
//   config_empty        : no config row available
//   config_rd_en        : pops the offered config row (written into the table)
//   new_cmp_config      : level, a new configuration is arriving
//   read_addr_start/addr_diff_start : search start address and initial step
//   config_applied      : 1-cycle pulse when the configuration is installed
//   cmp_in/cmp_wr_en/cmp_full : lookup request handshake
//   cmp_result_valid/cmp_equal/cmp_index/cmp_result_rd_en : result handshake
// -----------------------------------------------------------------------------
module cmp_search #(
  parameter int HASH_MSB     = 34,
  parameter int RAM_ADDR_MSB = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [HASH_MSB:0]       hash_in,
  input  logic [RAM_ADDR_MSB:0]   hash_addr_in,
  input  logic                    hash_valid_in,
  input  logic                    hash_end_in,
  input  logic                    config_empty,
  output logic                    config_rd_en,
  input  logic                    new_cmp_config,
  input  logic [RAM_ADDR_MSB-1:0] read_addr_start,
  input  logic [RAM_ADDR_MSB-1:0] addr_diff_start,
  output logic                    config_applied,
  input  logic [HASH_MSB:0]       cmp_in,
  input  logic                    cmp_wr_en,
  output logic                    cmp_full,
  output logic                    cmp_result_valid,
  output logic                    cmp_equal,
  output logic [RAM_ADDR_MSB:0]   cmp_index,
  input  logic                    cmp_result_rd_en
);

  localparam int DEPTH = 2 ** (RAM_ADDR_MSB + 1);
  localparam int ROW_W = HASH_MSB + 2;

  typedef enum logic [1:0] {IDLE, CONFIG, READ, CMP} state_t;

  state_t                  state_q;
  logic                    configured_q;
  logic                    cfg_pending_q;
  logic                    new_cfg_q;     // previous new_cmp_config, for edge detect
  logic [RAM_ADDR_MSB-1:0] start_q;
  logic [RAM_ADDR_MSB-1:0] diff_q;
  logic [RAM_ADDR_MSB:0]   addr_q;
  logic [RAM_ADDR_MSB:0]   step_q;
  logic [HASH_MSB:0]       key_q;

  logic [ROW_W-1:0]        ram [DEPTH];
  logic [ROW_W-1:0]        rd_row_q;

  logic                    accept;
  logic                    cfg_rise;
  logic                    row_valid;
  logic [HASH_MSB:0]       row_hash;
  logic                    row_hit;
  logic                    row_below;

  // Rows are offered show-ahead: the row on the inputs is consumed on the
  // edge where config_rd_en is high.
  assign config_rd_en = (state_q == CONFIG) & ~config_empty;
  assign cmp_full     = ~configured_q | cfg_pending_q | (state_q != IDLE) | cmp_result_valid;
  assign accept       = cmp_wr_en & ~cmp_full;
  // Only a rising edge arms a reconfiguration, so a level still held after
  // the acknowledge does not start a second one.
  assign cfg_rise     = new_cmp_config & ~new_cfg_q;

  // Invalid rows sort above every key, so they are never "below".
  assign row_valid = rd_row_q[HASH_MSB+1];
  assign row_hash  = rd_row_q[HASH_MSB:0];
  assign row_hit   = row_valid & (row_hash == key_q);
  assign row_below = row_valid & (row_hash < key_q);

  // NOTE: the table RAM has no reset branch; a memory cannot be cleared in
  // one cycle, and its power-up contents come from the device initialisation,
  // so rows written before a reset survive it.
  always_ff @(posedge clk) begin
    if (config_rd_en) begin
      ram[hash_addr_in] <= {hash_valid_in, hash_in};
    end
    rd_row_q <= ram[addr_q];
  end

  // NOTE: every register here uses non-blocking assignments so all state
  // advances together on the edge, whatever order the statements appear in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      configured_q     <= 1'b0;
      cfg_pending_q    <= 1'b0;
      new_cfg_q        <= 1'b0;
      start_q          <= '0;
      diff_q           <= '0;
      addr_q           <= '0;
      step_q           <= '0;
      key_q            <= '0;
      config_applied   <= 1'b0;
      cmp_result_valid <= 1'b0;
      cmp_equal        <= 1'b0;
      cmp_index        <= '0;
    end else begin
      new_cfg_q      <= new_cmp_config;
      config_applied <= 1'b0;

      if (cmp_result_rd_en) begin
        cmp_result_valid <= 1'b0;
      end
      if (cfg_rise) begin
        cfg_pending_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          // A pending configuration wins over a new lookup.
          if (cfg_pending_q) begin
            state_q <= CONFIG;
          end else if (accept) begin
            key_q   <= cmp_in;
            addr_q  <= {1'b0, start_q};
            step_q  <= {1'b0, diff_q};
            state_q <= READ;
          end
        end

        CONFIG: begin
          if (config_rd_en && hash_end_in) begin
            start_q        <= read_addr_start;
            diff_q         <= addr_diff_start;
            configured_q   <= 1'b1;
            cfg_pending_q  <= 1'b0;
            config_applied <= 1'b1;
            state_q        <= IDLE;
          end
        end

        // addr_q is presented to the RAM; its row is in rd_row_q in CMP.
        READ: state_q <= CMP;

        CMP: begin
          if (row_hit || (step_q == '0)) begin
            cmp_result_valid <= 1'b1;
            cmp_equal        <= row_hit;
            cmp_index        <= addr_q;
            state_q          <= IDLE;
          end else begin
            // With a power-of-two step the probe walk stays inside the table.
            addr_q  <= row_below ? (addr_q + step_q) : (addr_q - step_q);
            step_q  <= step_q >> 1;
            state_q <= READ;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_search.sv
// -----------------------------------------------------------------------------
// tb_cmp_search
// Self-checking bench for cmp_search. A behavioural model (array of table
// rows plus the binary-search walk over plain integers) predicts each lookup's
// result and latency; one negedge process compares every DUT output each cycle.
// -----------------------------------------------------------------------------
module tb_cmp_search;

  localparam int HM    = 34;
  localparam int AM    = 11;
  localparam int DEPTH = 1 << (AM + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [HM:0]   hash_in = '0;
  logic [AM:0]   hash_addr_in = '0;
  logic          hash_valid_in = 1'b0;
  logic          hash_end_in = 1'b0;
  logic          config_empty = 1'b1;
  logic          config_rd_en;
  logic          new_cmp_config = 1'b0;
  logic [AM-1:0] read_addr_start = '0;
  logic [AM-1:0] addr_diff_start = '0;
  logic          config_applied;
  logic [HM:0]   cmp_in = '0;
  logic          cmp_wr_en = 1'b0;
  logic          cmp_full;
  logic          cmp_result_valid;
  logic          cmp_equal;
  logic [AM:0]   cmp_index;
  logic          cmp_result_rd_en = 1'b0;

  cmp_search #(.HASH_MSB(HM), .RAM_ADDR_MSB(AM)) dut (
    .clk              (clk),
    .rst              (rst),
    .hash_in          (hash_in),
    .hash_addr_in     (hash_addr_in),
    .hash_valid_in    (hash_valid_in),
    .hash_end_in      (hash_end_in),
    .config_empty     (config_empty),
    .config_rd_en     (config_rd_en),
    .new_cmp_config   (new_cmp_config),
    .read_addr_start  (read_addr_start),
    .addr_diff_start  (addr_diff_start),
    .config_applied   (config_applied),
    .cmp_in           (cmp_in),
    .cmp_wr_en        (cmp_wr_en),
    .cmp_full         (cmp_full),
    .cmp_result_valid (cmp_result_valid),
    .cmp_equal        (cmp_equal),
    .cmp_index        (cmp_index),
    .cmp_result_rd_en (cmp_result_rd_en)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [DEPTH];
  bit [HM:0]   m_hash  [DEPTH];
  int          m_start = 0;
  int          m_diff  = 0;

  // Expected-output state consumed by the compare process.
  bit          exp_active     = 1'b0;
  int          exp_due        = 0;
  bit          exp_eq         = 1'b0;
  int          exp_idx        = 0;
  int          exp_applied_at = -1;
  bit          exp_configured = 1'b0;

  typedef struct {
    int        addr;
    bit        valid;
    bit [HM:0] hash;
  } row_t;
  row_t cfg_rows[$];

  // Binary-search walk over the model table: returns hit flag, final row and
  // number of probes taken.
  function automatic void model_search(input bit [HM:0] key, output bit eq,
                                       output int idx, output int pr);
    int a;
    int s;
    a  = m_start;
    s  = m_diff;
    pr = 0;
    eq = 1'b0;
    idx = 0;
    for (int n = 0; n < 16; n++) begin
      pr++;
      if (m_valid[a] && m_hash[a] == key) begin
        eq  = 1'b1;
        idx = a;
        return;
      end
      if (s == 0) begin
        idx = a;
        return;
      end
      if (m_valid[a] && m_hash[a] < key) a = a + s;
      else                               a = a - s;
      s = s / 2;
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("config_applied", {63'd0, config_applied}, {63'd0, (cyc == exp_applied_at)});
    if (config_empty) check("pop_when_empty", {63'd0, config_rd_en}, 64'd0);
    if (exp_active && cyc < exp_due) check("pop_during_search", {63'd0, config_rd_en}, 64'd0);
    if (!exp_configured || exp_active) check("cmp_full", {63'd0, cmp_full}, 64'd1);
    if (exp_active && cyc >= exp_due) begin
      check("result_valid", {63'd0, cmp_result_valid}, 64'd1);
      check("cmp_equal", {63'd0, cmp_equal}, {63'd0, exp_eq});
      check("cmp_index", {52'd0, cmp_index}, 64'(exp_idx));
    end else begin
      check("result_idle", {63'd0, cmp_result_valid}, 64'd0);
    end
  end

  // ---------------- drivers ----------------
  task automatic push_config(input int start, input int diff);
    int  a;
    bit  last;
    bit  got;
    read_addr_start = AM'(start);
    addr_diff_start = AM'(diff);
    new_cmp_config  = 1'b1;
    for (int i = 0; i < cfg_rows.size(); i++) begin
      a    = cfg_rows[i].addr;
      last = (i == cfg_rows.size() - 1);
      got  = 1'b0;
      hash_in       = cfg_rows[i].hash;
      hash_addr_in  = (AM+1)'(a);
      hash_valid_in = cfg_rows[i].valid;
      hash_end_in   = last;
      config_empty  = 1'b0;
      for (int t = 0; t < 300; t++) begin
        @(negedge clk);
        if (config_rd_en) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        check("pop_timeout", 64'd0, 64'd1);
        config_empty = 1'b1;
        hash_end_in  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      m_valid[a] = cfg_rows[i].valid;
      m_hash[a]  = cfg_rows[i].hash;
      if (last) begin
        m_start        = start;
        m_diff         = diff;
        exp_applied_at = cyc;
        exp_configured = 1'b1;
      end
    end
    config_empty = 1'b1;
    hash_end_in  = 1'b0;
  endtask

  task automatic drop_cfg();
    new_cmp_config = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic lookup_start(input bit [HM:0] key, input bit lit, input bit l_eq,
                              input int l_idx, input int l_pr);
    bit eq;
    int idx;
    int pr;
    bit got;
    model_search(key, eq, idx, pr);
    if (lit) begin
      check("model_eq", {63'd0, eq}, {63'd0, l_eq});
      check("model_idx", 64'(idx), 64'(l_idx));
      check("model_probes", 64'(pr), 64'(l_pr));
    end
    got = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!cmp_full) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("accept_timeout", 64'd0, 64'd1);
      return;
    end
    cmp_in    = key;
    cmp_wr_en = 1'b1;
    @(posedge clk);
    #1;
    cmp_wr_en  = 1'b0;
    exp_eq     = eq;
    exp_idx    = idx;
    exp_due    = cyc + 2 * pr;
    exp_active = 1'b1;
  endtask

  task automatic lookup_finish(input int delay);
    if (!exp_active) return;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (cyc >= exp_due) break;
    end
    repeat (delay) @(negedge clk);
    cmp_result_rd_en = 1'b1;
    @(posedge clk);
    #1;
    cmp_result_rd_en = 1'b0;
    exp_active       = 1'b0;
  endtask

  task automatic lookup(input bit [HM:0] key, input bit lit, input bit l_eq,
                        input int l_idx, input int l_pr, input int delay);
    lookup_start(key, lit, l_eq, l_idx, l_pr);
    lookup_finish(delay);
  endtask

  task automatic add_row(input int a, input bit v, input bit [HM:0] h);
    row_t r;
    r.addr  = a;
    r.valid = v;
    r.hash  = h;
    cfg_rows.push_back(r);
  endtask

  task automatic table_a();
    cfg_rows.delete();
    for (int i = 0; i < 5; i++) add_row(i, 1'b1, (HM+1)'(10 * (i + 1)));
    add_row(5, 1'b0, '0);
    add_row(6, 1'b0, '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int        k;
    int        n;
    int        nv;
    int        sel;
    longint    h;
    bit [HM:0] key;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", {63'd0, cmp_result_valid}, 64'd0);
    check("rst_equal", {63'd0, cmp_equal}, 64'd0);
    check("rst_index", {52'd0, cmp_index}, 64'd0);
    check("rst_rd_en", {63'd0, config_rd_en}, 64'd0);
    check("rst_applied", {63'd0, config_applied}, 64'd0);
    check("rst_full", {63'd0, cmp_full}, 64'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("unconfigured_full", {63'd0, cmp_full}, 64'd1);

    // Table A: {10,20,30,40,50} at 0..4, 5..6 invalid, start 3, step 2
    table_a();
    push_config(3, 2);
    drop_cfg();
    lookup(35'd40, 1'b1, 1'b1, 3, 1, 0);
    lookup(35'd50, 1'b1, 1'b1, 4, 3, 1);
    lookup(35'd35, 1'b1, 1'b0, 2, 3, 0);
    lookup(35'd5,  1'b1, 1'b0, 0, 3, 2);

    // New configuration arrives during a 3-probe search on table A
    fork
      begin
        lookup_start(35'd50, 1'b1, 1'b1, 4, 3);
        lookup_finish(3);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        cfg_rows.delete();
        add_row(0, 1'b1, 35'd7);
        push_config(0, 0);
        drop_cfg();
      end
    join

    // Single-row table
    lookup(35'd7, 1'b1, 1'b1, 0, 1, 0);
    lookup(35'd8, 1'b1, 1'b0, 0, 1, 0);

    // Shrinking reconfiguration, level held after the acknowledge
    cfg_rows.delete();
    add_row(0, 1'b1, 35'd20);
    add_row(1, 1'b1, 35'd30);
    for (int i = 2; i < 5; i++) add_row(i, 1'b0, '0);
    push_config(1, 1);
    repeat (5) begin
      @(negedge clk);
      check("no_retrigger", {63'd0, cmp_full}, 64'd0);
    end
    drop_cfg();
    lookup(35'd50, 1'b1, 1'b0, 2, 2, 0);
    lookup(35'd30, 1'b1, 1'b1, 1, 1, 0);

    // Randomised tables; the last one uses the full depth (max probes)
    for (int r = 0; r < 6; r++) begin
      k  = (r == 5) ? AM : int'($urandom_range(1, 4));
      n  = (1 << (k + 1)) - 1;
      nv = int'($urandom_range(1, n));
      h  = longint'($urandom_range(0, 1000));
      cfg_rows.delete();
      for (int i = 0; i < n; i++) begin
        if (i < nv) begin
          add_row(i, 1'b1, (HM+1)'(h));
          h = h + 1 + longint'($urandom_range(0, 1 << 20));
        end else begin
          add_row(i, 1'b0, (HM+1)'({$urandom(), $urandom()}));
        end
      end
      push_config((1 << k) - 1, 1 << (k - 1));
      drop_cfg();
      for (int q = 0; q < 15; q++) begin
        sel = int'($urandom_range(0, 3));
        key = m_hash[$urandom_range(0, nv - 1)];
        if (sel == 2) key = ($urandom_range(0, 1) == 1) ? key + 1'b1 : key - 1'b1;
        if (sel == 3) key = (HM+1)'(longint'({$urandom(), $urandom()}) % (h + 10));
        lookup(key, 1'b0, 1'b0, 0, 0, int'($urandom_range(0, 2)));
      end
    end

    // Reset in the middle of a search
    table_a();
    push_config(3, 2);
    drop_cfg();
    lookup_start(35'd35, 1'b1, 1'b0, 2, 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst            = 1'b1;
    exp_active     = 1'b0;
    exp_configured = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    // Reconfigure with a single invalid row; rows 0..5 survive the reset.
    cfg_rows.delete();
    add_row(6, 1'b0, '0);
    push_config(3, 2);
    drop_cfg();
    lookup(35'd50, 1'b1, 1'b1, 4, 3, 0);
    lookup(35'd35, 1'b1, 1'b0, 2, 3, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    check("watchdog", 64'd0, 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
